wb_arbiter_2m: RTL
==================

Name: wb_arbiter_2m

Overview:
- Two-master to one-slave Wishbone arbiter for the CPU core.
- Master 0 is the data-side Wishbone bus interface; master 1 is the instruction-side Wishbone bus interface.
- The single slave port drives the shared system bus.
- Arbitration is round-robin (optionally fixed priority), with a bus-hang timeout that returns an error to the stuck master and frees the bus.

Parameters:
- FIXED_PRIO, 0, 1 = master 0 always wins simultaneous requests; 0 = round-robin.
- TIMEOUT_CYCLES, 1024, number of granted cycles with stb high and no ack before a timeout fires. 0 disables the timeout. Max 65535.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- m0_cyc_i / m0_stb_i / m0_we_i  in  1 each  master 0 cycle, strobe, write enable
- m0_sel_i  in  4  master 0 byte select
- m0_addr_i / m0_data_i  in  32 each  master 0 address, write data
- m0_data_o  out  32  read data to master 0
- m0_ack_o / m0_err_o  out  1 each  acknowledge, timeout error to master 0
- m1_*  same set and widths as m0_*, for master 1
- s_cyc_o / s_stb_o / s_we_o  out  1 each  slave-side cycle, strobe, write enable
- s_sel_o  out  4  slave byte select
- s_addr_o / s_data_o  out  32 each  slave address, write data
- s_data_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = none

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, last_grant = 1, timeout counter = 0.
  - grant_o = 00.
  - All s_* outputs, mX_ack_o, mX_err_o and mX_data_o are 0, taking effect immediately, including mid-transfer.
- States: IDLE, GNT0, GNT1, ERR_WAIT.
- IDLE:
  - No slave outputs are driven (all 0).
  - Requests are sampled via mX_cyc_i. Next state is GNT0 or GNT1. Arbitration latency is 1 cycle from cyc to grant.
  - Only one requester: grant it.
  - Both requesting with FIXED_PRIO = 1: grant m0.
  - Both requesting with FIXED_PRIO = 0: grant the master not equal to last_grant. Because last_grant resets to 1, m0 wins the first tie.
  - last_grant is updated on entry to each GNT state.
- GNTx:
  - s_* outputs are a combinational mux of the granted master's inputs.
  - s_ack_i is routed combinationally to mx_ack_o only.
  - mx_data_o = s_data_i. The non-granted master sees ack = 0 and data = 0.
  - The grant is held while mx_cyc_i = 1, covering multiple strobes and back-to-back transfers.
  - When mx_cyc_i = 0, go to IDLE next cycle. There is always at least 1 IDLE cycle between owners.
- Timeout counter (16-bit):
  - Clears on every state entry and on any cycle with s_ack_i = 1.
  - Increments each GNT cycle with mx_stb_i = 1 and s_ack_i = 0.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack in that cycle, and TIMEOUT_CYCLES != 0:
    - Pulse mx_err_o for exactly 1 cycle, in the following cycle.
    - Go to ERR_WAIT.
  - If the ack arrives in that same cycle, the ack wins and no error is raised.
- ERR_WAIT:
  - All s_* outputs are 0 and the slave is released.
  - grant_o keeps the owner bit.
  - Late s_ack_i is ignored and not forwarded.
  - Stay until the owner drops cyc, then go to IDLE.
- A requester that drops cyc before being granted is not granted: the grant decision uses cyc in the IDLE cycle only.
- A slave ack with no grant is ignored.

Test Plan:
- m0 only: cyc/stb high, addr 0x0000_1000, we = 0; slave acks on the 3rd cycle with 0xDEADBEEF.
  - Required: grant_o = 01 one cycle after cyc; s_addr_o = 0x0000_1000; m0_ack_o coincident with s_ack_i; m0_data_o = 0xDEADBEEF; m1_ack_o stays 0.
- m0 and m1 assert cyc in the same cycle, each doing 3 transactions back-to-back, FIXED_PRIO = 0.
  - Required: grant order m0, m1, m0, m1, m0, m1, with exactly 1 IDLE cycle (grant_o = 00) between owners.
- Same stimulus with FIXED_PRIO = 1.
  - Required: all m0 transactions are served before the first m1 grant.
- TIMEOUT_CYCLES = 8; m1 strobes and the slave never acks.
  - Required: m1_err_o pulses high for 1 cycle after 8 stalled cycles; s_cyc_o = 0 from then; grant_o stays 10 until m1 drops cyc, then 00.
  - An s_ack_i injected during ERR_WAIT must not reach m1_ack_o.
- Ack on the exact timeout cycle (TIMEOUT_CYCLES = 8, ack on the 8th stalled cycle).
  - Required: m1_ack_o = 1, m1_err_o never asserted.
- Assert rst asynchronously mid-transfer while grant_o = 01.
  - Required: grant_o = 00 and all s_* outputs = 0 without waiting for a clock edge.
  - After release with both masters requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter with round-robin/fixed priority and bus-hang timeout
module wb_arbiter_2m #(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR_WAIT} state_t;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic T_EN = TIMEOUT_CYCLES != 0;
  state_t      state_q, state_d;
  logic        last_q, last_d, err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        g0, g1, own_cyc, own_stb, fire, pick1;
  always_comb begin
    g0 = state_q == GNT0;
    g1 = state_q == GNT1;
    own_cyc = grant_q[1] ? m1_cyc_i : m0_cyc_i;
    own_stb = g1 ? m1_stb_i : g0 & m0_stb_i;
    fire = (g0 | g1) & own_cyc & own_stb & ~s_ack_i & T_EN & (cnt_q == T_LAST);
    pick1 = m1_cyc_i & (~m0_cyc_i | (~FIXED_PRIO & ~last_q));
    state_d = state_q == IDLE     ? ((m0_cyc_i | m1_cyc_i) ? (pick1 ? GNT1 : GNT0) : IDLE) :
              state_q == ERR_WAIT ? (own_cyc ? ERR_WAIT : IDLE) :
              ~own_cyc ? IDLE : fire ? ERR_WAIT : state_q;
    last_d = state_d == GNT1 ? 1'b1 : state_d == GNT0 ? 1'b0 : last_q;
    // Any state change or slave ack restarts the stall count
    cnt_d = (state_d != state_q || s_ack_i) ? 16'd0 : cnt_q + 16'(own_stb);
    grant_d = state_d == GNT0 ? 2'b01 : state_d == GNT1 ? 2'b10 :
              state_d == ERR_WAIT ? grant_q : 2'b00;
    err_d = fire;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end
  assign s_cyc_o   = g0 ? m0_cyc_i  : g1 & m1_cyc_i;
  assign s_stb_o   = g0 ? m0_stb_i  : g1 & m1_stb_i;
  assign s_we_o    = g0 ? m0_we_i   : g1 & m1_we_i;
  assign s_sel_o   = g0 ? m0_sel_i  : g1 ? m1_sel_i  : '0;
  assign s_addr_o  = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
  assign s_data_o  = g0 ? m0_data_i : g1 ? m1_data_i : '0;
  assign m0_ack_o  = g0 & s_ack_i;
  assign m1_ack_o  = g1 & s_ack_i;
  assign m0_data_o = g0 ? s_data_i : '0;
  assign m1_data_o = g1 ? s_data_i : '0;
  assign m0_err_o  = err_q & grant_q[0];
  assign m1_err_o  = err_q & grant_q[1];
  assign grant_o   = grant_q;
endmodule
